// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: recovery sequencer for N lockstep cores.
// Detects comparator errors, holds the cores in reset, then drives recovery
// until done or a watchdog expires; retries up to MAX_RETRIES, then FATAL.
// Optional: define FT_ERR_COUNT_EN to add err_count_o, a saturating count of
// accepted detections from IDLE (retries are not counted).
module ft_recovery_ctrl #(
  parameter int unsigned NUM_ERR        = 3,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 2,
  localparam int unsigned RW            = $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [NUM_ERR-1:0] error_i,
  input  logic               recovery_done_i,
`ifdef FT_ERR_COUNT_EN
  output logic [15:0]        err_count_o,
`endif
  output logic               reset_core_no,
  output logic               recover_o,
  output logic               busy_o,
  output logic               fatal_o,
  output logic [NUM_ERR-1:0] fault_src_o,
  output logic [RW-1:0]      retry_cnt_o
);

  localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES);
  localparam logic [TW-1:0]  WD_LAST  = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RECOVER,
    S_FATAL
  } state_e;

  state_e             state_q;
  logic [RCW-1:0]     rst_cnt_q;
  logic [TW-1:0]      wd_q;
  logic               reset_core_n_q;
  logic               recover_q;
  logic               busy_q;
  logic               fatal_q;
  logic [NUM_ERR-1:0] fault_src_q;
  logic [RW-1:0]      retry_q;
`ifdef FT_ERR_COUNT_EN
  logic [15:0]        err_count_q;
`endif

  logic any_err;
  assign any_err = |error_i;

  // Recovery FSM: state, counters and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      wd_q           <= '0;
      reset_core_n_q <= 1'b1;
      recover_q      <= 1'b0;
      busy_q         <= 1'b0;
      fatal_q        <= 1'b0;
      fault_src_q    <= '0;
      retry_q        <= '0;
`ifdef FT_ERR_COUNT_EN
      err_count_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i && any_err) begin
            state_q        <= S_RESET;
            rst_cnt_q      <= RCW'(1);
            reset_core_n_q <= 1'b0;
            busy_q         <= 1'b1;
            fault_src_q    <= error_i;
            retry_q        <= '0;
`ifdef FT_ERR_COUNT_EN
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
`endif
          end
        end

        // rst_cnt_q holds the index (1-based) of the current reset cycle.
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q        <= S_RECOVER;
            reset_core_n_q <= 1'b1;
            recover_q      <= 1'b1;
            wd_q           <= TW'(1);
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end

        // Done has priority over a simultaneous timeout or new error.
        S_RECOVER: begin
          if (recovery_done_i) begin
            state_q   <= S_IDLE;
            recover_q <= 1'b0;
            busy_q    <= 1'b0;
            retry_q   <= '0;
          end else if ((wd_q == WD_LAST) || any_err) begin
            recover_q      <= 1'b0;
            reset_core_n_q <= 1'b0;
            fault_src_q    <= fault_src_q | error_i;
            if (retry_q == RETRY_MAX) begin
              state_q <= S_FATAL;
              busy_q  <= 1'b0;
              fatal_q <= 1'b1;
            end else begin
              state_q   <= S_RESET;
              rst_cnt_q <= RCW'(1);
              retry_q   <= retry_q + 1'b1;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_FATAL: begin
          reset_core_n_q <= 1'b0;
          recover_q      <= 1'b0;
          busy_q         <= 1'b0;
          fatal_q        <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reset_core_no = reset_core_n_q;
  assign recover_o     = recover_q;
  assign busy_o        = busy_q;
  assign fatal_o       = fatal_q;
  assign fault_src_o   = fault_src_q;
  assign retry_cnt_o   = retry_q;
`ifdef FT_ERR_COUNT_EN
  assign err_count_o   = err_count_q;
`endif

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb_ft_recovery_ctrl: directed vector table plus hand-written sequences for
// the retry/FATAL path and (when FT_ERR_COUNT_EN is defined) the error counter.
module tb_ft_recovery_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] err;
  logic       done;
  logic       rcn;
  logic       rec;
  logic       busy;
  logic       fat;
  logic [2:0] src;
  logic [1:0] retry;
`ifdef FT_ERR_COUNT_EN
  logic [15:0] ecnt;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  ft_recovery_ctrl #(
    .NUM_ERR(3),
    .RESET_CYCLES(2),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(en),
    .error_i(err),
    .recovery_done_i(done),
`ifdef FT_ERR_COUNT_EN
    .err_count_o(ecnt),
`endif
    .reset_core_no(rcn),
    .recover_o(rec),
    .busy_o(busy),
    .fatal_o(fat),
    .fault_src_o(src),
    .retry_cnt_o(retry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] err;
    logic       done;
    logic       rcn;
    logic       rec;
    logic       busy;
    logic       fat;
    logic [2:0] src;
    logic [1:0] retry;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [2:0] er, input logic d,
                     input logic xrcn, input logic xrec, input logic xbusy, input logic xfat,
                     input logic [2:0] xsrc, input logic [1:0] xretry);
    vec_t v;
    v.rst = r; v.en = e; v.err = er; v.done = d;
    v.rcn = xrcn; v.rec = xrec; v.busy = xbusy; v.fat = xfat; v.src = xsrc; v.retry = xretry;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic xrcn, input logic xrec, input logic xbusy,
                         input logic xfat, input logic [2:0] xsrc, input logic [1:0] xretry);
    logic [9:0] got;
    logic [9:0] exp;
    got = {rcn, rec, busy, fat, src, retry, 1'b0};
    exp = {xrcn, xrec, xbusy, xfat, xsrc, xretry, 1'b0};
    chk($sformatf("%s {rcn,rec,busy,fatal,src,retry}", tag), 32'(got >> 1), 32'(exp >> 1));
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [2:0] er, input logic d);
    rst = r; en = e; err = er; done = d;
    @(posedge clk);
    #1;
  endtask

`ifdef FT_ERR_COUNT_EN
  task automatic episode(input logic [2:0] er, input bit with_retry);
    step(0, 1, er, 0);
    step(0, 1, 3'b000, 0);
    step(0, 1, 3'b000, 0);
    if (with_retry) begin
      step(0, 1, 3'b001, 0);
      step(0, 1, 3'b000, 0);
      step(0, 1, 3'b000, 0);
    end
    step(0, 1, 3'b000, 1);
    step(0, 1, 3'b000, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; err = '0; done = 1'b0;

    //   rst en err  done | rcn rec busy fat src   retry
    // reset then idle
    add(1, 0, 3'b000, 0,   1, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 3'b000, 0, 1, 0, 0, 0, 3'b000, 0);
    // single-cycle error, done in 3rd RECOVER cycle
    add(0, 1, 3'b010, 0,   0, 0, 1, 0, 3'b010, 0);
    add(0, 1, 3'b000, 0,   0, 0, 1, 0, 3'b010, 0);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b010, 0);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b010, 0);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b010, 0);
    add(0, 1, 3'b000, 1,   1, 0, 0, 0, 3'b010, 0);
    add(0, 1, 3'b000, 0,   1, 0, 0, 0, 3'b010, 0);
    // new fault in RECOVER cycle 2 -> retry; then done beats error
    add(0, 1, 3'b001, 0,   0, 0, 1, 0, 3'b001, 0);
    add(0, 1, 3'b000, 0,   0, 0, 1, 0, 3'b001, 0);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b001, 0);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b001, 0);
    add(0, 1, 3'b100, 0,   0, 0, 1, 0, 3'b101, 1);
    add(0, 1, 3'b000, 0,   0, 0, 1, 0, 3'b101, 1);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b101, 1);
    add(0, 1, 3'b000, 0,   1, 1, 1, 0, 3'b101, 1);
    add(0, 1, 3'b100, 1,   1, 0, 0, 0, 3'b101, 0);
    // enable gating; drop enable and inject error during RESET
    add(0, 0, 3'b111, 0,   1, 0, 0, 0, 3'b101, 0);
    add(0, 0, 3'b111, 0,   1, 0, 0, 0, 3'b101, 0);
    add(0, 1, 3'b011, 0,   0, 0, 1, 0, 3'b011, 0);
    add(0, 0, 3'b100, 0,   0, 0, 1, 0, 3'b011, 0);
    add(0, 0, 3'b000, 0,   1, 1, 1, 0, 3'b011, 0);
    add(0, 0, 3'b000, 1,   1, 0, 0, 0, 3'b011, 0);
    // reset mid-sequence aborts
    add(0, 1, 3'b001, 0,   0, 0, 1, 0, 3'b001, 0);
    add(1, 1, 3'b000, 0,   1, 0, 0, 0, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].err, vecs[i].done);
      chk_all($sformatf("vec%0d", i), vecs[i].rcn, vecs[i].rec, vecs[i].busy,
              vecs[i].fat, vecs[i].src, vecs[i].retry);
    end

    // Never-done sequence: 3 attempts, 8-cycle watchdog each, then FATAL.
    step(0, 1, 3'b001, 0);
    for (int a = 0; a < 3; a++) begin
      chk_all($sformatf("att%0d_rst1", a), 0, 0, 1, 0, 3'b001, 2'(a));
      step(0, 1, 3'b000, 0);
      chk_all($sformatf("att%0d_rst2", a), 0, 0, 1, 0, 3'b001, 2'(a));
      for (int c = 1; c <= 8; c++) begin
        step(0, 1, 3'b000, 0);
        chk_all($sformatf("att%0d_rec%0d", a, c), 1, 1, 1, 0, 3'b001, 2'(a));
      end
      step(0, 1, 3'b000, 0);
    end
    chk_all("fatal_entry", 0, 0, 0, 1, 3'b001, 2);
    step(0, 1, 3'b111, 1);
    step(0, 1, 3'b010, 0);
    chk_all("fatal_sticky", 0, 0, 0, 1, 3'b001, 2);
    step(1, 0, 3'b000, 0);
    step(0, 0, 3'b000, 0);
    chk_all("fatal_cleared", 1, 0, 0, 0, 3'b000, 0);

`ifdef FT_ERR_COUNT_EN
    episode(3'b001, 0);
    episode(3'b010, 1);
    episode(3'b100, 0);
    chk("err_count_3", 32'(ecnt), 32'd3);
    step(1, 0, 3'b000, 0);
    step(0, 0, 3'b000, 0);
    chk("err_count_rst", 32'(ecnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
